// File: rtl/mem_lsu_mc.sv
// mem_lsu_mc: multi-cycle load/store unit for the MEM stage of the MIPS pipeline.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   MEM_valid, MEM_allow_in,        pipeline control: instruction present,
//   MEM_cancel                      pipeline advance, flush of the MEM instruction
//   ls_op, addr, store_data, rt_old instruction operands (see op codes below)
//   dm_req, dm_wr, dm_addr,         data-memory request side
//   dm_wen, dm_wdata, dm_ready
//   dm_rvalid, dm_rdata             data-memory read-return side
//   MEM_over, ld_result             completion flag and load result for WB
//   exc_adel, exc_ades, exc_bus,    exception flags and faulting address,
//   bad_vaddr                       meaningful while MEM_over is high
//   dbg_state                       current FSM state: 0 IDLE, 1 REQ, 2 WAIT,
//                                   3 DONE, 4 DRAIN
//
// Handshake: a request is live while dm_req is high; dm_wr/dm_addr/dm_wen/dm_wdata
// are held constant until the cycle dm_ready is sampled high, which accepts it.
// A read returns exactly one dm_rvalid pulse some cycles after acceptance.
module mem_lsu_mc #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MEM_valid,
  input  logic              MEM_allow_in,
  input  logic              MEM_cancel,
  input  logic [3:0]        ls_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  input  logic [31:0]       rt_old,
  output logic              dm_req,
  output logic              dm_wr,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_wen,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ready,
  input  logic              dm_rvalid,
  input  logic [31:0]       dm_rdata,
  output logic              MEM_over,
  output logic [31:0]       ld_result,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic              exc_bus,
  output logic [ADDR_W-1:0] bad_vaddr,
  output logic [2:0]        dbg_state
);

  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW = 4'd5, OP_LWL = 4'd6, OP_LWR = 4'd7;
  localparam logic [3:0] OP_SB = 4'd9, OP_SH = 4'd10, OP_SW = 4'd11;
  localparam logic [3:0] OP_SWL = 4'd12, OP_SWR = 4'd13;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  function automatic logic is_load(input logic [3:0] op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR};
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return op inside {OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR};
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
    return ((op inside {OP_LH, OP_LHU, OP_SH}) && a[0]) ||
           ((op inside {OP_LW, OP_SW}) && (a != 2'b00));
  endfunction

  state_t            state, state_nx;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       rt_old_q;
  logic [CNT_W-1:0]  cnt;
  logic              drain_pend;  // a timed-out read may still return data

  logic accept, mis_in, ld_capture, to_evt, release_done, timeout_hit;
  logic [3:0]  wen_c;
  logic [31:0] wdata_c, ld_c;
  logic [1:0]  a_in, a_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign a_in      = addr[1:0];
  assign a_q       = addr_q[1:0];
  assign mis_in    = is_misaligned(ls_op, a_in);
  assign dbg_state = state;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign MEM_over  = (state == S_DONE) ||
                     ((state == S_IDLE) && MEM_valid && !is_load(ls_op) && !is_store(ls_op));

  // Store byte-lane steering from the incoming operands.
  always_comb begin
    wen_c   = 4'b0000;
    wdata_c = 32'h0;
    case (ls_op)
      OP_SB: begin wen_c = 4'b0001 << a_in; wdata_c = {4{store_data[7:0]}}; end
      OP_SH: begin wen_c = a_in[1] ? 4'b1100 : 4'b0011; wdata_c = {2{store_data[15:0]}}; end
      OP_SW: begin wen_c = 4'b1111; wdata_c = store_data; end
      OP_SWL: case (a_in)
        2'd0:    begin wen_c = 4'b0001; wdata_c = {24'h0, store_data[31:24]}; end
        2'd1:    begin wen_c = 4'b0011; wdata_c = {16'h0, store_data[31:16]}; end
        2'd2:    begin wen_c = 4'b0111; wdata_c = {8'h0, store_data[31:8]}; end
        default: begin wen_c = 4'b1111; wdata_c = store_data; end
      endcase
      OP_SWR: case (a_in)
        2'd0:    begin wen_c = 4'b1111; wdata_c = store_data; end
        2'd1:    begin wen_c = 4'b1110; wdata_c = {store_data[23:0], 8'h0}; end
        2'd2:    begin wen_c = 4'b1100; wdata_c = {store_data[15:0], 16'h0}; end
        default: begin wen_c = 4'b1000; wdata_c = {store_data[7:0], 24'h0}; end
      endcase
      default: ;
    endcase
  end

  // Load extraction from returned data using the latched operation.
  always_comb begin
    case (a_q)
      2'd0:    byte_sel = dm_rdata[7:0];
      2'd1:    byte_sel = dm_rdata[15:8];
      2'd2:    byte_sel = dm_rdata[23:16];
      default: byte_sel = dm_rdata[31:24];
    endcase
    half_sel = a_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    ld_c     = dm_rdata;
    case (op_q)
      OP_LB:  ld_c = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: ld_c = {24'h0, byte_sel};
      OP_LH:  ld_c = {{16{half_sel[15]}}, half_sel};
      OP_LHU: ld_c = {16'h0, half_sel};
      OP_LWL: case (a_q)
        2'd0:    ld_c = {dm_rdata[7:0], rt_old_q[23:0]};
        2'd1:    ld_c = {dm_rdata[15:0], rt_old_q[15:0]};
        2'd2:    ld_c = {dm_rdata[23:0], rt_old_q[7:0]};
        default: ld_c = dm_rdata;
      endcase
      OP_LWR: case (a_q)
        2'd0:    ld_c = dm_rdata;
        2'd1:    ld_c = {rt_old_q[31:24], dm_rdata[31:8]};
        2'd2:    ld_c = {rt_old_q[31:16], dm_rdata[31:16]};
        default: ld_c = {rt_old_q[31:8], dm_rdata[31:24]};
      endcase
      default: ld_c = dm_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Event priority in REQ: acceptance, then cancel, then timeout.
  // In WAIT: returned data, then cancel, then timeout.
  always_comb begin
    state_nx     = state;
    accept       = 1'b0;
    ld_capture   = 1'b0;
    to_evt       = 1'b0;
    release_done = 1'b0;
    case (state)
      S_IDLE:
        if (MEM_valid && !MEM_cancel && (is_load(ls_op) || is_store(ls_op))) begin
          accept   = 1'b1;
          state_nx = mis_in ? S_DONE : S_REQ;
        end
      S_REQ:
        if (dm_ready) begin
          // An accepted store is committed even when cancelled.
          if (is_store(op_q))  state_nx = S_DONE;
          else if (MEM_cancel) state_nx = S_DRAIN;
          else                 state_nx = S_WAIT;
        end else if (MEM_cancel) begin
          state_nx = S_IDLE;
        end else if (timeout_hit) begin
          to_evt   = 1'b1;
          state_nx = S_DONE;
        end
      S_WAIT:
        if (dm_rvalid) begin
          ld_capture = !MEM_cancel;
          state_nx   = MEM_cancel ? S_IDLE : S_DONE;
        end else if (MEM_cancel) begin
          state_nx = S_DRAIN;
        end else if (timeout_hit) begin
          to_evt   = 1'b1;
          state_nx = S_DONE;
        end
      S_DONE:
        if (MEM_allow_in || MEM_cancel) begin
          release_done = 1'b1;
          // A late read that arrives on this very cycle needs no draining.
          state_nx = (drain_pend && !dm_rvalid) ? S_DRAIN : S_IDLE;
        end
      S_DRAIN:
        if (dm_rvalid) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= 4'h0;
      addr_q     <= '0;
      rt_old_q   <= 32'h0;
      cnt        <= '0;
      drain_pend <= 1'b0;
      dm_req     <= 1'b0;
      dm_wr      <= 1'b0;
      dm_addr    <= '0;
      dm_wen     <= 4'h0;
      dm_wdata   <= 32'h0;
      ld_result  <= 32'h0;
      exc_adel   <= 1'b0;
      exc_ades   <= 1'b0;
      exc_bus    <= 1'b0;
      bad_vaddr  <= '0;
    end else begin
      dm_req <= (state_nx == S_REQ);
      if (accept) begin
        op_q     <= ls_op;
        addr_q   <= addr;
        rt_old_q <= rt_old;
        cnt      <= '0;
        if (mis_in) begin
          exc_adel  <= is_load(ls_op);
          exc_ades  <= is_store(ls_op);
          bad_vaddr <= addr;
        end else begin
          dm_wr    <= is_store(ls_op);
          dm_addr  <= {addr[ADDR_W-1:2], 2'b00};
          dm_wen   <= wen_c;
          dm_wdata <= wdata_c;
        end
      end
      if (state == S_REQ || state == S_WAIT) cnt <= cnt + 1'b1;
      if (state == S_REQ && state_nx != S_REQ) begin
        dm_wr    <= 1'b0;
        dm_addr  <= '0;
        dm_wen   <= 4'h0;
        dm_wdata <= 32'h0;
      end
      if (to_evt) begin
        exc_bus    <= 1'b1;
        bad_vaddr  <= addr_q;
        drain_pend <= (state == S_WAIT);
      end
      if (ld_capture) ld_result <= ld_c;
      if (state == S_DONE && dm_rvalid) drain_pend <= 1'b0;
      if (release_done) begin
        exc_adel   <= 1'b0;
        exc_ades   <= 1'b0;
        exc_bus    <= 1'b0;
        drain_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu_mc.sv
// tb_mem_lsu_mc: table-driven, hand-sequenced and randomized checks of mem_lsu_mc
// against a byte-level reference model.
module tb_mem_lsu_mc;

  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW = 4'd5, OP_LWL = 4'd6, OP_LWR = 4'd7;
  localparam logic [3:0] OP_SB = 4'd9, OP_SH = 4'd10, OP_SW = 4'd11;
  localparam logic [3:0] OP_SWL = 4'd12, OP_SWR = 4'd13;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_WAIT = 3'd2, ST_DRAIN = 3'd4;

  logic        clk, reset;
  logic        MEM_valid, MEM_allow_in, MEM_cancel;
  logic [3:0]  ls_op;
  logic [31:0] addr, store_data, rt_old;
  logic        dm_req, dm_wr, dm_ready, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata, ld_result, bad_vaddr;
  logic [3:0]  dm_wen;
  logic        MEM_over, exc_adel, exc_ades, exc_bus;
  logic [2:0]  dbg_state;

  mem_lsu_mc #(.ADDR_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .MEM_valid(MEM_valid), .MEM_allow_in(MEM_allow_in),
    .MEM_cancel(MEM_cancel), .ls_op(ls_op), .addr(addr), .store_data(store_data),
    .rt_old(rt_old), .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr),
    .dm_wen(dm_wen), .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata), .MEM_over(MEM_over), .ld_result(ld_result),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_bus(exc_bus),
    .bad_vaddr(bad_vaddr), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    reset = 1'b1; MEM_valid = 1'b0; MEM_allow_in = 1'b0; MEM_cancel = 1'b0;
    ls_op = 4'h0; addr = 32'h0; store_data = 32'h0; rt_old = 32'h0;
    dm_ready = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_ld = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic m_is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LWR);
  endfunction

  function automatic logic m_misaligned(input logic [3:0] op, input int a);
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return (a % 2) != 0;
    if (op == OP_LW || op == OP_SW) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input int a,
                                         input logic [31:0] r, input logic [31:0] old);
    logic [7:0] rb[4], ob[4], res[4];
    logic [15:0] h;
    for (int i = 0; i < 4; i++) begin
      rb[i] = r[8*i +: 8]; ob[i] = old[8*i +: 8]; res[i] = ob[i];
    end
    h = {rb[(a/2)*2 + 1], rb[(a/2)*2]};
    case (op)
      OP_LB:  return {{24{rb[a][7]}}, rb[a]};
      OP_LBU: return {24'h0, rb[a]};
      OP_LH:  return {{16{h[15]}}, h};
      OP_LHU: return {16'h0, h};
      OP_LWL: for (int i = 0; i < 4; i++) if (i >= 3 - a) res[i] = rb[i - (3 - a)];
      OP_LWR: for (int i = 0; i < 4; i++) if (i <= 3 - a) res[i] = rb[i + a];
      default: return r;
    endcase
    return {res[3], res[2], res[1], res[0]};
  endfunction

  task automatic m_store(input logic [3:0] op, input int a, input logic [31:0] sd,
                         output logic [3:0] wen, output logic [31:0] wdata);
    logic [7:0] sb[4];
    for (int i = 0; i < 4; i++) sb[i] = sd[8*i +: 8];
    wen = 4'h0; wdata = 32'h0;
    for (int j = 0; j < 4; j++) begin
      case (op)
        OP_SB:  begin wen[j] = (j == a); wdata[8*j +: 8] = sb[0]; end
        OP_SH:  begin wen[j] = (j / 2 == a / 2); wdata[8*j +: 8] = sb[j % 2]; end
        OP_SW:  begin wen[j] = 1'b1; wdata[8*j +: 8] = sb[j]; end
        OP_SWL: if (j <= a) begin wen[j] = 1'b1; wdata[8*j +: 8] = sb[j + 3 - a]; end
        OP_SWR: if (j >= a) begin wen[j] = 1'b1; wdata[8*j +: 8] = sb[j - a]; end
        default: ;
      endcase
    end
  endtask

  // ---------------- driver / memory responder ----------------
  typedef struct {
    int over_k, req_cycles;
    logic [3:0] wen;
    logic [31:0] wdata, daddr, result, bad;
    logic wr, adel, ades, bus, req_at_over, held, unstable;
  } obs_t;

  // Presents one instruction at cycle N (k=0) and plays memory: dm_ready after
  // rlat request cycles, dm_rvalid vlat cycles after acceptance. Holds the
  // instruction for 'hold' cycles after MEM_over before MEM_allow_in.
  task automatic do_access(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] old, input logic [31:0] rd,
                           input int rlat, input int vlat, input int hold, output obs_t o);
    int age, rk;
    bit rdy, fin;
    o.over_k = -1; o.req_cycles = 0; o.wen = 4'h0; o.wdata = 32'h0; o.daddr = 32'h0;
    o.result = 32'h0; o.bad = 32'h0; o.wr = 1'b0; o.adel = 1'b0; o.ades = 1'b0;
    o.bus = 1'b0; o.req_at_over = 1'b0; o.held = 1'b1; o.unstable = 1'b0;
    age = 0; rk = 0; rdy = 1'b0; fin = 1'b0;
    @(negedge clk);
    MEM_valid = 1'b1; ls_op = op; addr = a; store_data = sd; rt_old = old;
    for (int k = 1; k <= 60 && !fin; k++) begin
      @(negedge clk);
      dm_ready = 1'b0; dm_rvalid = 1'b0; dm_rdata = $urandom;
      if (MEM_over) begin
        o.over_k = k; o.result = ld_result; o.adel = exc_adel; o.ades = exc_ades;
        o.bus = exc_bus; o.bad = bad_vaddr; o.req_at_over = dm_req;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          if (!MEM_over) o.held = 1'b0;
        end
        MEM_allow_in = 1'b1;
        @(negedge clk);
        fin = 1'b1;
      end else begin
        if (dm_req && !rdy) begin
          o.req_cycles++;
          if (o.req_cycles > 1 &&
              (dm_wen !== o.wen || dm_wdata !== o.wdata || dm_wr !== o.wr || dm_addr !== o.daddr))
            o.unstable = 1'b1;
          o.wen = dm_wen; o.wdata = dm_wdata; o.wr = dm_wr; o.daddr = dm_addr;
          if (age == rlat) begin dm_ready = 1'b1; rdy = 1'b1; rk = k; end
          age++;
        end
        if (rdy && k != rk && k == rk + vlat) begin dm_rvalid = 1'b1; dm_rdata = rd; end
      end
    end
    MEM_allow_in = 1'b0; MEM_valid = 1'b0; ls_op = 4'h0; dm_ready = 1'b0; dm_rvalid = 1'b0;
  endtask

  task automatic check_obs(input string tag, input obs_t o, input logic [31:0] exp_res,
                           input logic [3:0] op, input logic [31:0] a, input logic [3:0] ewen,
                           input logic [31:0] ewdata, input logic [1:0] eexc,
                           input int rlat, input int vlat);
    logic ld, mis;
    int exp_k;
    ld  = m_is_load(op);
    mis = (eexc != 2'b00);
    exp_k = mis ? 1 : (ld ? 2 + rlat + vlat : 2 + rlat);
    chk({tag, "_over_cycle"}, 64'(o.over_k), 64'(exp_k));
    chk({tag, "_result"}, o.result, exp_res);
    chk({tag, "_exc"}, {o.adel, o.ades, o.bus}, {eexc, 1'b0});
    if (mis) begin
      chk({tag, "_no_req"}, 64'(o.req_cycles), 64'd0);
      chk({tag, "_bad_vaddr"}, o.bad, a);
    end else begin
      chk({tag, "_req_cycles"}, 64'(o.req_cycles), 64'(rlat + 1));
      chk({tag, "_dm_wr"}, o.wr, !ld);
      chk({tag, "_dm_wen"}, o.wen, ld ? 4'h0 : ewen);
      if (!ld) chk({tag, "_dm_wdata"}, o.wdata, ewdata);
      chk({tag, "_dm_addr"}, o.daddr, {a[31:2], 2'b00});
      chk({tag, "_stable"}, o.unstable, 1'b0);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] op; logic [31:0] a, sd, old, rd; int rlat, vlat;
    logic [31:0] exp_res; logic [3:0] exp_wen; logic [31:0] exp_wdata; logic [1:0] exp_exc;
  } vec_t;

  vec_t vecs[13];

  initial begin
    obs_t o;
    logic [31:0] e, a, sd, old, rd, ew_d;
    logic [3:0] op, ew;
    logic [1:0] ex;
    logic mis, seen;
    int rl, vl, ai;
    logic [3:0] ops[12];

    vecs[0]  = '{OP_LW,  32'h100, 32'h0, 32'h0, 32'h8899AABB, 0, 1, 32'h8899AABB, 4'h0, 32'h0, 2'b00};
    vecs[1]  = '{OP_LB,  32'h103, 32'h0, 32'h0, 32'h80112233, 0, 1, 32'hFFFFFF80, 4'h0, 32'h0, 2'b00};
    vecs[2]  = '{OP_LBU, 32'h103, 32'h0, 32'h0, 32'h80112233, 0, 1, 32'h00000080, 4'h0, 32'h0, 2'b00};
    vecs[3]  = '{OP_LH,  32'h102, 32'h0, 32'h0, 32'h80112233, 0, 1, 32'hFFFF8011, 4'h0, 32'h0, 2'b00};
    vecs[4]  = '{OP_SWL, 32'h101, 32'hA1B2C3D4, 32'h0, 32'h0, 0, 1, 32'h0, 4'b0011, 32'h0000A1B2, 2'b00};
    vecs[5]  = '{OP_LWR, 32'h102, 32'h0, 32'h11223344, 32'h55667788, 0, 1, 32'h11225566, 4'h0, 32'h0, 2'b00};
    vecs[6]  = '{OP_SW,  32'h102, 32'h12345678, 32'h0, 32'h0, 0, 1, 32'h0, 4'h0, 32'h0, 2'b01};
    vecs[7]  = '{OP_LH,  32'h101, 32'h0, 32'h0, 32'h0, 0, 1, 32'h0, 4'h0, 32'h0, 2'b10};
    vecs[8]  = '{OP_SB,  32'h202, 32'h0000005A, 32'h0, 32'h0, 2, 1, 32'h0, 4'b0100, 32'h5A5A5A5A, 2'b00};
    vecs[9]  = '{OP_SH,  32'h302, 32'h1234BEEF, 32'h0, 32'h0, 1, 1, 32'h0, 4'b1100, 32'hBEEFBEEF, 2'b00};
    vecs[10] = '{OP_SWR, 32'h403, 32'hCAFEF00D, 32'h0, 32'h0, 0, 1, 32'h0, 4'b1000, 32'h0D000000, 2'b00};
    vecs[11] = '{OP_LWL, 32'h500, 32'h0, 32'h11223344, 32'hAABBCCDD, 1, 2, 32'hDD223344, 4'h0, 32'h0, 2'b00};
    vecs[12] = '{OP_LHU, 32'h500, 32'h0, 32'h0, 32'h1234F00D, 2, 1, 32'h0000F00D, 4'h0, 32'h0, 2'b00};
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR, OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR};

    apply_reset();
    chk("reset_ctrl", {dm_req, dm_wr, dm_wen, MEM_over, exc_adel, exc_ades, exc_bus, dbg_state}, 64'd0);
    chk("reset_data", {dm_wdata, ld_result}, 64'd0);
    chk("reset_addr", {dm_addr, bad_vaddr}, 64'd0);

    // Op "none" and an undefined code complete combinationally in IDLE.
    @(negedge clk);
    MEM_valid = 1'b1; ls_op = 4'h0;
    #1 chk("none_over", MEM_over, 1'b1);
    ls_op = 4'd8;
    #1 chk("undef_over", MEM_over, 1'b1);
    @(negedge clk);
    chk("none_no_req", {dm_req, dbg_state}, {1'b0, ST_IDLE});
    MEM_valid = 1'b0; ls_op = 4'h0;

    for (int i = 0; i < 13; i++) begin
      mis = (vecs[i].exp_exc != 2'b00);
      exp_q.push_back((m_is_load(vecs[i].op) && !mis) ? vecs[i].exp_res : last_ld);
      do_access(vecs[i].op, vecs[i].a, vecs[i].sd, vecs[i].old, vecs[i].rd,
                vecs[i].rlat, vecs[i].vlat, 0, o);
      e = exp_q.pop_front();
      check_obs($sformatf("vec%0d", i), o, e, vecs[i].op, vecs[i].a, vecs[i].exp_wen,
                vecs[i].exp_wdata, vecs[i].exp_exc, vecs[i].rlat, vecs[i].vlat);
      last_ld = e;
    end

    // Memory never accepts: bus error after 8 REQ cycles, held until allow_in.
    do_access(OP_LW, 32'h800, 32'h0, 32'h0, 32'h0, 99, 1, 3, o);
    chk("to_req_over_cycle", 64'(o.over_k), 64'd9);
    chk("to_req_req_cycles", 64'(o.req_cycles), 64'd8);
    chk("to_req_flags", {o.bus, o.adel, o.ades, o.req_at_over, o.held}, 5'b10001);
    chk("to_req_bad_vaddr", o.bad, 32'h800);
    chk("to_req_result", o.result, last_ld);
    chk("to_req_idle", dbg_state, ST_IDLE);

    // Read accepted but data never returns in time; late rvalid is drained.
    do_access(OP_LW, 32'h700, 32'h0, 32'h0, 32'h0, 0, 50, 2, o);
    chk("to_wait_over_cycle", 64'(o.over_k), 64'd9);
    chk("to_wait_flags", {o.bus, o.adel, o.ades, o.held}, 4'b1001);
    chk("to_wait_bad_vaddr", o.bad, 32'h700);
    chk("to_wait_drain", dbg_state, ST_DRAIN);
    @(negedge clk);
    dm_rvalid = 1'b1; dm_rdata = 32'h0BADF00D;
    @(negedge clk);
    dm_rvalid = 1'b0;
    chk("to_wait_after_drain", {MEM_over, dbg_state}, {1'b0, ST_IDLE});
    chk("to_wait_result", ld_result, last_ld);

    // Cancel while waiting for read data; data 3 cycles later is discarded.
    @(negedge clk);
    MEM_valid = 1'b1; ls_op = OP_LW; addr = 32'h600;
    @(negedge clk);
    chk("cw_req", dm_req, 1'b1);
    dm_ready = 1'b1;
    @(negedge clk);
    dm_ready = 1'b0; MEM_cancel = 1'b1; seen = MEM_over;
    chk("cw_wait", dbg_state, ST_WAIT);
    @(negedge clk);
    MEM_cancel = 1'b0; MEM_valid = 1'b0; ls_op = 4'h0; seen |= MEM_over;
    chk("cw_drain", dbg_state, ST_DRAIN);
    @(negedge clk);
    seen |= MEM_over;
    @(negedge clk);
    dm_rvalid = 1'b1; dm_rdata = 32'hDEADBEEF; seen |= MEM_over;
    @(negedge clk);
    dm_rvalid = 1'b0; seen |= MEM_over;
    chk("cw_idle", dbg_state, ST_IDLE);
    chk("cw_no_over", seen, 1'b0);
    chk("cw_result", ld_result, last_ld);
    exp_q.push_back(32'h13579BDF);
    do_access(OP_LW, 32'h604, 32'h0, 32'h0, 32'h13579BDF, 0, 1, 0, o);
    e = exp_q.pop_front();
    check_obs("cw_next", o, e, OP_LW, 32'h604, 4'h0, 32'h0, 2'b00, 0, 1);
    last_ld = e;

    // Cancel while the request is still pending drops it.
    @(negedge clk);
    MEM_valid = 1'b1; ls_op = OP_LW; addr = 32'h900;
    @(negedge clk);
    chk("cr_req", dm_req, 1'b1);
    MEM_cancel = 1'b1;
    @(negedge clk);
    chk("cr_dropped", {dm_req, MEM_over, dbg_state}, {2'b00, ST_IDLE});
    MEM_cancel = 1'b0; MEM_valid = 1'b0; ls_op = 4'h0;

    // Randomized accesses against the byte-level model.
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 11)];
      a = $urandom; sd = $urandom; old = $urandom; rd = $urandom;
      rl = $urandom_range(0, 2); vl = $urandom_range(1, 2);
      ai = int'(a[1:0]);
      mis = m_misaligned(op, ai);
      ex = {mis && m_is_load(op), mis && !m_is_load(op)};
      m_store(op, ai, sd, ew, ew_d);
      exp_q.push_back((m_is_load(op) && !mis) ? m_load(op, ai, rd, old) : last_ld);
      do_access(op, a, sd, old, rd, rl, vl, $urandom_range(0, 1), o);
      e = exp_q.pop_front();
      check_obs($sformatf("rnd%0d_op%0d", n, op), o, e, op, a, ew, ew_d, ex, rl, vl);
      last_ld = e;
    end

    // Reset in the middle of WAIT clears everything at once.
    @(negedge clk);
    MEM_valid = 1'b1; ls_op = OP_LW; addr = 32'hA00;
    @(negedge clk);
    dm_ready = 1'b1;
    @(negedge clk);
    dm_ready = 1'b0;
    chk("rw_wait", dbg_state, ST_WAIT);
    reset = 1'b1;
    #1;
    chk("rw_ctrl", {dm_req, dm_wr, dm_wen, exc_adel, exc_ades, exc_bus, dbg_state}, 64'd0);
    chk("rw_data", {dm_wdata, ld_result}, 64'd0);
    chk("rw_addr", {dm_addr, bad_vaddr}, 64'd0);
    MEM_valid = 1'b0; ls_op = 4'h0;
    chk("rw_over", MEM_over, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    dm_rvalid = 1'b1; dm_rdata = 32'hFEEDFACE;
    @(negedge clk);
    dm_rvalid = 1'b0;
    chk("rw_ignored", {MEM_over, dbg_state, ld_result}, {1'b0, ST_IDLE, 32'h0});
    last_ld = 32'h0;
    exp_q.push_back(32'h2468ACE0);
    do_access(OP_LW, 32'hB00, 32'h0, 32'h0, 32'h2468ACE0, 1, 1, 0, o);
    e = exp_q.pop_front();
    check_obs("rw_next", o, e, OP_LW, 32'hB00, 4'h0, 32'h0, 2'b00, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
